pad_controller_gen: RTL and testbench



---
 rtl/pad_controller_gen_if.sv | 29 ++
 rtl/pad_controller_gen.sv | 175 +++++++++++++++++
 tb/tb_pad_controller_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pad_controller_gen_if.sv
// Paddle controller bus: the per-tick control inputs and the registered pad outputs.
interface pad_controller_gen_if #(
   parameter int Y_W = 10
);
   logic           timing_tick;
   logic [1:0]     mode;
   logic           btn_up;
   logic           btn_down;
   logic [Y_W-1:0] y_remote;
   logic           y_remote_valid;
   logic [Y_W-1:0] ball_y;
   logic [Y_W-1:0] y_pad;
   logic           moving;
   logic           dir_down;
   logic           at_top;
   logic           at_bottom;

   // Game logic side: drives controls, observes the pad.
   modport master (
      output timing_tick, mode, btn_up, btn_down, y_remote, y_remote_valid, ball_y,
      input  y_pad, moving, dir_down, at_top, at_bottom
   );

   // Controller side.
   modport slave (
      input  timing_tick, mode, btn_up, btn_down, y_remote, y_remote_valid, ball_y,
      output y_pad, moving, dir_down, at_top, at_bottom
   );
endinterface

// File: rtl/pad_controller_gen.sv
// Paddle position controller: local buttons with acceleration, remote position,
// automatic ball tracking and hold. Updates once per timing_tick and outputs a
// registered top-of-pad Y clamped to [MARGIN, SCREEN_H-PAD_H-MARGIN].
module pad_controller_gen #(
   parameter int Y_W         = 10,
   parameter int SCREEN_H    = 768,
   parameter int PAD_H       = 145,
   parameter int MARGIN      = 4,
   parameter int Y_RESET     = 312,
   parameter int V_MIN       = 3,
   parameter int V_MAX       = 8,
   parameter int ACCEL_TICKS = 4,
   parameter int V_AI        = 4,
   parameter int AI_DEADBAND = 2
) (
   input logic                clk,
   input logic                rst_n,
   pad_controller_gen_if.slave bus
);

   localparam int SW    = Y_W + 2;
   localparam int VEL_W = $clog2(V_MAX + 2);
   localparam int CNT_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

   localparam logic signed [SW-1:0] Y_MIN_S  = SW'(MARGIN);
   localparam logic signed [SW-1:0] Y_MAX_S  = SW'(SCREEN_H - PAD_H - MARGIN);
   localparam logic signed [SW-1:0] HALF_S   = SW'(PAD_H / 2);
   localparam logic signed [SW-1:0] V_AI_S   = SW'(V_AI);
   localparam logic signed [SW-1:0] DB_S     = SW'(AI_DEADBAND);
   localparam logic [VEL_W-1:0]     V_MIN_V  = VEL_W'(V_MIN);
   localparam logic [VEL_W-1:0]     V_MAX_V  = VEL_W'(V_MAX);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ACCEL_TICKS - 1);
   localparam logic [Y_W-1:0]       Y_MIN_U  = Y_W'(MARGIN);
   localparam logic [Y_W-1:0]       Y_MAX_U  = Y_W'(SCREEN_H - PAD_H - MARGIN);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] MOVE_UP   = 2'd1;
   localparam logic [1:0] MOVE_DOWN = 2'd2;

   localparam logic [1:0] M_LOCAL  = 2'b00;
   localparam logic [1:0] M_REMOTE = 2'b01;
   localparam logic [1:0] M_AUTO   = 2'b10;

   logic [Y_W-1:0]   y_pad, shadow;
   logic [1:0]       state, mode_q;
   logic [VEL_W-1:0] vel;
   logic [CNT_W-1:0] cnt;
   logic             dir_down;

   logic [Y_W-1:0]   y_next;
   logic [1:0]       state_next;
   logic [VEL_W-1:0] vel_next;
   logic [CNT_W-1:0] cnt_next;
   logic             dir_next;

   logic             mode_chg;
   logic [1:0]       state_eff;
   logic [VEL_W-1:0] vel_eff, v_use;
   logic [CNT_W-1:0] cnt_eff, c_use;
   logic             req_up, req_down;
   logic signed [SW-1:0] y_s, step, target, d, ad, mag;

   function automatic logic [Y_W-1:0] clamp_y(input logic signed [SW-1:0] v);
      if (v < Y_MIN_S)      clamp_y = Y_MIN_U;
      else if (v > Y_MAX_S) clamp_y = Y_MAX_U;
      else                  clamp_y = v[Y_W-1:0];
   endfunction

   // Remote shadow: latch every strobe in any mode, independent of the tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  shadow <= Y_W'(Y_RESET);
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      else if (bus.y_remote_valid) shadow <= clamp_y($signed({2'b00, bus.y_remote}));
   end

   // Next-state computation for the current tick.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_next = state;
      vel_next   = vel;
      cnt_next   = cnt;
      dir_next   = dir_down;
      step       = '0;
      target     = '0;
      d          = '0;
      ad         = '0;
      mag        = '0;
      v_use      = V_MIN_V;
      c_use      = '0;

      y_s       = $signed({2'b00, y_pad});
      mode_chg  = (bus.mode != mode_q);
      state_eff = mode_chg ? IDLE : state;
      vel_eff   = mode_chg ? V_MIN_V : vel;
      cnt_eff   = mode_chg ? '0 : cnt;
      req_down  = bus.btn_down & ~bus.btn_up;
      req_up    = bus.btn_up & ~bus.btn_down;

      case (bus.mode)
         M_LOCAL: begin
            if (!req_down && !req_up) begin
               state_next = IDLE;
               vel_next   = V_MIN_V;
               cnt_next   = '0;
            end else begin
               // Continuing in the same direction keeps speed; anything else restarts at V_MIN.
               if (state_eff == (req_down ? MOVE_DOWN : MOVE_UP)) begin
                  v_use = vel_eff;
                  c_use = cnt_eff;
               end
               step       = $signed({{(SW-VEL_W){1'b0}}, v_use});
               if (req_up) step = -step;
               state_next = req_down ? MOVE_DOWN : MOVE_UP;
               dir_next   = req_down;
               if (c_use == CNT_LAST) begin
                  cnt_next = '0;
                  vel_next = (v_use >= V_MAX_V) ? V_MAX_V : v_use + 1'b1;
               end else begin
                  cnt_next = c_use + 1'b1;
                  vel_next = v_use;
               end
            end
         end
         M_AUTO: begin
            vel_next   = V_MIN_V;
            cnt_next   = '0;
            target     = $signed({2'b00, clamp_y($signed({2'b00, bus.ball_y}) - HALF_S)});
            d          = target - y_s;
            ad         = (d < 0) ? -d : d;
            if (ad <= DB_S) begin
               state_next = IDLE;
            end else begin
               mag        = (ad > V_AI_S) ? V_AI_S : ad;
               step       = (d < 0) ? -mag : mag;
               state_next = (d < 0) ? MOVE_UP : MOVE_DOWN;
               dir_next   = (d > 0);
            end
         end
         default: begin
            // Remote and hold park the FSM; only remote changes position.
            state_next = IDLE;
            vel_next   = V_MIN_V;
            cnt_next   = '0;
         end
      endcase

      y_next = (bus.mode == M_REMOTE) ? shadow : clamp_y(y_s + step);
   end

   // Tick-qualified state update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_pad    <= Y_W'(Y_RESET);
         state    <= IDLE;
         vel      <= V_MIN_V;
         cnt      <= '0;
         dir_down <= 1'b0;
         mode_q   <= M_LOCAL;
      end else if (bus.timing_tick) begin
         y_pad    <= y_next;
         state    <= state_next;
         vel      <= vel_next;
         cnt      <= cnt_next;
         dir_down <= dir_next;
         mode_q   <= bus.mode;
      end
   end

   assign bus.y_pad     = y_pad;
   assign bus.moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
   assign bus.dir_down  = dir_down;
   assign bus.at_top    = (y_pad == Y_MIN_U);
   assign bus.at_bottom = (y_pad == Y_MAX_U);

endmodule

// File: tb/tb_pad_controller_gen.sv
// Directed-vector bench for pad_controller_gen with hand-computed expectations.
module tb_pad_controller_gen;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   pad_controller_gen_if #(.Y_W(10)) bus ();

   pad_controller_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // One update strobe; returns on the falling edge after the capturing edge.
   task automatic tick();
      @(negedge clk);
      bus.timing_tick = 1'b1;
      @(negedge clk);
      bus.timing_tick = 1'b0;
   endtask

   task automatic strobe(input int v);
      @(negedge clk);
      bus.y_remote       = 10'(v);
      bus.y_remote_valid = 1'b1;
      @(negedge clk);
      bus.y_remote_valid = 1'b0;
   endtask

   // Place the pad through the remote path.
   task automatic set_y(input int v);
      bus.mode = 2'b01;
      strobe(v);
      tick();
   endtask

   int accel_exp[6] = '{315, 318, 321, 324, 328, 332};
   int rev_exp[8]   = '{303, 306, 309, 312, 316, 320, 324, 328};
   int auto_exp[3]  = '{308, 304, 300};

   initial begin
      rst_n              = 1'b0;
      bus.timing_tick    = 1'b0;
      bus.mode           = 2'b00;
      bus.btn_up         = 1'b0;
      bus.btn_down       = 1'b0;
      bus.y_remote       = '0;
      bus.y_remote_valid = 1'b0;
      bus.ball_y         = '0;
      repeat (2) @(negedge clk);
      check("rst_y", bus.y_pad, 312);
      check("rst_moving", bus.moving, 0);
      check("rst_dir", bus.dir_down, 0);
      check("rst_top", bus.at_top, 0);
      check("rst_bot", bus.at_bottom, 0);
      rst_n = 1'b1;

      // Asynchronous reset mid-cycle
      set_y(500);
      check("pre_rst_y", bus.y_pad, 500);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_y", bus.y_pad, 312);
      check("async_rst_moving", bus.moving, 0);
      check("async_rst_top", bus.at_top, 0);
      check("async_rst_bot", bus.at_bottom, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Acceleration
      bus.mode     = 2'b00;
      bus.btn_down = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("accel_y%0d", i), bus.y_pad, accel_exp[i]);
      end
      check("accel_dir", bus.dir_down, 1);
      check("accel_moving", bus.moving, 1);
      bus.btn_down = 1'b0;
      tick();
      check("release_moving", bus.moving, 0);
      check("release_y", bus.y_pad, 332);
      bus.btn_down = 1'b1;
      tick();
      check("repress_y", bus.y_pad, 335);

      // Bottom clamp
      bus.btn_down = 1'b0;
      set_y(617);
      bus.mode     = 2'b00;
      bus.btn_down = 1'b1;
      tick();
      check("bot_y", bus.y_pad, 619);
      check("bot_flag", bus.at_bottom, 1);
      tick();
      check("bot_hold_y", bus.y_pad, 619);
      check("bot_hold_moving", bus.moving, 1);

      // Both buttons, then reversal at vel 5
      set_y(300);
      bus.mode     = 2'b00;
      bus.btn_up   = 1'b1;
      bus.btn_down = 1'b1;
      tick();
      check("both_y", bus.y_pad, 300);
      check("both_moving", bus.moving, 0);
      bus.btn_up = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("rev_down_y%0d", i), bus.y_pad, rev_exp[i]);
      end
      bus.btn_up   = 1'b1;
      bus.btn_down = 1'b0;
      tick();
      check("rev_up_y", bus.y_pad, 325);
      check("rev_up_dir", bus.dir_down, 0);

      // Hold ignores buttons
      bus.mode = 2'b11;
      tick();
      check("hold_y", bus.y_pad, 325);
      check("hold_moving", bus.moving, 0);

      // Top clamp via remote shadow, then a held up button at the limit
      bus.btn_up = 1'b0;
      set_y(0);
      check("top_y", bus.y_pad, 4);
      check("top_flag", bus.at_top, 1);
      bus.mode   = 2'b00;
      bus.btn_up = 1'b1;
      tick();
      check("top_hold_y", bus.y_pad, 4);
      bus.btn_up = 1'b0;

      // Remote: last strobe wins, shadow clamps
      bus.mode = 2'b01;
      strobe(700);
      strobe(200);
      tick();
      check("remote_last_y", bus.y_pad, 200);
      strobe(700);
      tick();
      check("remote_clamp_y", bus.y_pad, 619);
      check("remote_bot", bus.at_bottom, 1);

      // Auto tracking
      set_y(312);
      bus.mode   = 2'b10;
      bus.ball_y = 10'd100;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("auto_y%0d", i), bus.y_pad, auto_exp[i]);
      end
      check("auto_dir", bus.dir_down, 0);
      set_y(312);
      bus.mode   = 2'b10;
      bus.ball_y = 10'd385;
      tick();
      check("auto_db_y", bus.y_pad, 312);
      check("auto_db_moving", bus.moving, 0);
      bus.ball_y = 10'd387;
      tick();
      check("auto_small_y", bus.y_pad, 315);
      check("auto_small_dir", bus.dir_down, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
